sdft_spectrum_buffer: RTL

- Sits directly downstream of sdft_top and consumes its per-bin write stream (real, imag, address, enable).
- Converts each complex bin to an approximate magnitude.
- Collects a complete frame of g_N magnitudes in a double-buffered RAM.
- Presents the last complete frame on a synchronous read port for the display/readout side, signalling each new frame.

---
 rtl/sdft_pkg.sv | 27 ++
 rtl/sdft_mag_approx.sv | 112 +++++++++++
 rtl/sdft_spectrum_buffer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdft_pkg.sv
// sdft_pkg: shared defaults, bin-word type and the beta shift constants used by
// the SDFT spectrum buffer and its magnitude approximation pipeline.
`timescale 1ns/1ps
package sdft_pkg;

  // Default configuration of the spectrum buffer.
  localparam int unsigned C_N_DEFAULT         = 32'd512;
  localparam int unsigned C_IN_WIDTH_DEFAULT  = 32'd32;
  localparam int unsigned C_MAG_WIDTH_DEFAULT = 32'd16;
  localparam int unsigned C_SHIFT_DEFAULT     = 32'd16;
  localparam int unsigned C_ADDR_W_DEFAULT    = $clog2(C_N_DEFAULT);

  // Width of the published-frame counter.
  localparam int unsigned C_FRAME_CNT_W = 32'd16;

  // Beta term of alpha-max-beta-min: min/4 + min/8 (beta = 0.375).
  localparam int unsigned C_BETA_SHIFT_A = 32'd2;
  localparam int unsigned C_BETA_SHIFT_B = 32'd3;

  // One bin word as produced by sdft_top in the default configuration.
  typedef struct packed {
    logic signed [C_IN_WIDTH_DEFAULT-1:0] re;
    logic signed [C_IN_WIDTH_DEFAULT-1:0] im;
    logic [C_ADDR_W_DEFAULT-1:0]          addr;
  } bin_word_t;

endpackage

// File: rtl/sdft_mag_approx.sv
// sdft_mag_approx: three-stage complex magnitude estimate.
//   S1 saturating |re|, |im|; S2 max/min; S3 max + min/4 + min/8, >> g_SHIFT,
//   saturated to g_MAG_WIDTH bits. Valid, address and a 1-bit tag ride along.
`timescale 1ns/1ps
module sdft_mag_approx
  import sdft_pkg::*;
#(
  parameter int unsigned g_IN_WIDTH  = C_IN_WIDTH_DEFAULT,
  parameter int unsigned g_MAG_WIDTH = C_MAG_WIDTH_DEFAULT,
  parameter int unsigned g_SHIFT     = C_SHIFT_DEFAULT,
  parameter int unsigned g_ADDR_W    = C_ADDR_W_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_tag,
  input  logic [g_IN_WIDTH-1:0]  i_real,
  input  logic [g_IN_WIDTH-1:0]  i_imag,
  input  logic [g_ADDR_W-1:0]    i_addr,
  output logic                   o_valid,
  output logic                   o_tag,
  output logic [g_ADDR_W-1:0]    o_addr,
  output logic [g_MAG_WIDTH-1:0] o_mag
);

  localparam int unsigned C_RAW_W = g_IN_WIDTH + 32'd1;
  localparam logic [g_IN_WIDTH-1:0] C_MOST_NEG = {1'b1, {(g_IN_WIDTH-1){1'b0}}};
  localparam logic [g_IN_WIDTH-1:0] C_MOST_POS = {1'b0, {(g_IN_WIDTH-1){1'b1}}};
  localparam logic [g_IN_WIDTH-1:0] C_ONE      = {{(g_IN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_RAW_W-1:0]    C_MAG_MAX  =
    {{(C_RAW_W-g_MAG_WIDTH){1'b0}}, {g_MAG_WIDTH{1'b1}}};

  // Two's-complement absolute value; the most negative code has no positive
  // counterpart and is clamped to the largest positive value.
  function automatic logic [g_IN_WIDTH-1:0] sat_abs(input logic [g_IN_WIDTH-1:0] x);
    logic [g_IN_WIDTH-1:0] r;
    if (x == C_MOST_NEG) begin
      r = C_MOST_POS;
    end else if (x[g_IN_WIDTH-1]) begin
      r = ~x + C_ONE;
    end else begin
      r = x;
    end
    return r;
  endfunction

  logic                   v1_q, v2_q, v3_q;
  logic                   tag1_q, tag2_q, tag3_q;
  logic [g_ADDR_W-1:0]    addr1_q, addr2_q, addr3_q;
  logic [g_IN_WIDTH-1:0]  re_abs_q, im_abs_q, re_abs_d, im_abs_d;
  logic [g_IN_WIDTH-1:0]  mx_q, mn_q, mx_d, mn_d;
  logic [C_RAW_W-1:0]     raw_s, shifted_s;
  logic [g_MAG_WIDTH-1:0] mag_q, mag_d;

  // Next-state datapath for all three stages.
  always_comb begin
    re_abs_d = sat_abs(i_real);
    im_abs_d = sat_abs(i_imag);
    if (re_abs_q >= im_abs_q) begin
      mx_d = re_abs_q;
      mn_d = im_abs_q;
    end else begin
      mx_d = im_abs_q;
      mn_d = re_abs_q;
    end
    raw_s     = {1'b0, mx_q} + {1'b0, (mn_q >> C_BETA_SHIFT_A)}
                             + {1'b0, (mn_q >> C_BETA_SHIFT_B)};
    shifted_s = raw_s >> g_SHIFT;
    if (shifted_s > C_MAG_MAX) begin
      mag_d = {g_MAG_WIDTH{1'b1}};
    end else begin
      mag_d = shifted_s[g_MAG_WIDTH-1:0];
    end
  end

  // Stage valids and tag sideband; reset drops every bin in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tag1_q <= 1'b0;
      tag2_q <= 1'b0;
      tag3_q <= 1'b0;
    end else begin
      v1_q   <= i_valid;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      tag1_q <= i_tag & i_valid;
      tag2_q <= tag1_q;
      tag3_q <= tag2_q;
    end
  end

  // Stage data registers; qualified by the valids, so no reset is needed.
  always_ff @(posedge i_clk) begin
    re_abs_q <= re_abs_d;
    im_abs_q <= im_abs_d;
    mx_q     <= mx_d;
    mn_q     <= mn_d;
    mag_q    <= mag_d;
    addr1_q  <= i_addr;
    addr2_q  <= addr1_q;
    addr3_q  <= addr2_q;
  end

  assign o_valid = v3_q;
  assign o_tag   = tag3_q;
  assign o_addr  = addr3_q;
  assign o_mag   = mag_q;

endmodule

// File: rtl/sdft_spectrum_buffer.sv
// sdft_spectrum_buffer: turns the sdft_top bin stream into magnitudes, collects
// a frame into one half of a double-buffered RAM and publishes it to a
// 1-cycle-latency read port once every bin arrived in order.
// Optional build macro SDFT_SPECTRUM_PEAK_EN adds o_peakAddr/o_peakMag.
`timescale 1ns/1ps
module sdft_spectrum_buffer
  import sdft_pkg::*;
#(
  parameter int unsigned g_N         = C_N_DEFAULT,
  parameter int unsigned g_IN_WIDTH  = C_IN_WIDTH_DEFAULT,
  parameter int unsigned g_MAG_WIDTH = C_MAG_WIDTH_DEFAULT,
  parameter int unsigned g_SHIFT     = C_SHIFT_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [g_IN_WIDTH-1:0]    i_freqWrReal,
  input  logic [g_IN_WIDTH-1:0]    i_freqWrImag,
  input  logic [$clog2(g_N)-1:0]   i_freqWrAddr,
  input  logic                     i_freqWrEn,
  input  logic [$clog2(g_N)-1:0]   i_rdAddr,
  input  logic                     i_rdEn,
  output logic [g_MAG_WIDTH-1:0]   o_rdData,
  output logic                     o_rdValid,
  output logic                     o_frameReady,
  output logic [C_FRAME_CNT_W-1:0] o_frameCount,
  output logic                     o_seqError
`ifdef SDFT_SPECTRUM_PEAK_EN
  ,
  output logic [$clog2(g_N)-1:0]   o_peakAddr,
  output logic [g_MAG_WIDTH-1:0]   o_peakMag
`endif
);

  localparam int unsigned C_AW = $clog2(g_N);
  localparam logic [C_AW-1:0] C_LAST_ADDR = C_AW'(g_N - 32'd1);
  localparam logic [C_AW-1:0] C_ADDR_ONE  = C_AW'(32'd1);
  localparam logic [C_FRAME_CNT_W-1:0] C_CNT_ONE = C_FRAME_CNT_W'(32'd1);

  // ---------------------------------------------------------------- sequence
  logic [C_AW-1:0] expected_q, expected_d;
  logic            frame_bad_q, frame_bad_d;
  logic            seq_error_q, seq_error_d;
  logic            last_ok_s;

  // Address sequence check at pipeline entry; the last bin is tagged as
  // publishable only if the frame it closes is still clean.
  always_comb begin
    expected_d  = expected_q;
    frame_bad_d = frame_bad_q;
    seq_error_d = seq_error_q;
    last_ok_s   = 1'b0;
    if (i_freqWrEn) begin
      if (i_freqWrAddr == {C_AW{1'b0}}) begin
        frame_bad_d = 1'b0;
      end else if (i_freqWrAddr != expected_q) begin
        frame_bad_d = 1'b1;
        seq_error_d = 1'b1;
      end else begin
        frame_bad_d = frame_bad_q;
      end
      // g_N is a power of two, so g_N-1 + 1 wraps to 0 on its own.
      expected_d = i_freqWrAddr + C_ADDR_ONE;
      last_ok_s  = (i_freqWrAddr == C_LAST_ADDR) && !frame_bad_d;
    end else begin
      last_ok_s = 1'b0;
    end
  end

  // Sequence-check state registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      expected_q  <= {C_AW{1'b0}};
      frame_bad_q <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      expected_q  <= expected_d;
      frame_bad_q <= frame_bad_d;
      seq_error_q <= seq_error_d;
    end
  end

  // --------------------------------------------------------------- magnitude
  logic                   mag_valid_s;
  logic                   mag_tag_s;
  logic [C_AW-1:0]        mag_addr_s;
  logic [g_MAG_WIDTH-1:0] mag_s;

  sdft_mag_approx #(
    .g_IN_WIDTH  (g_IN_WIDTH),
    .g_MAG_WIDTH (g_MAG_WIDTH),
    .g_SHIFT     (g_SHIFT),
    .g_ADDR_W    (C_AW)
  ) u_mag (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_freqWrEn),
    .i_tag   (last_ok_s),
    .i_real  (i_freqWrReal),
    .i_imag  (i_freqWrImag),
    .i_addr  (i_freqWrAddr),
    .o_valid (mag_valid_s),
    .o_tag   (mag_tag_s),
    .o_addr  (mag_addr_s),
    .o_mag   (mag_s)
  );

  // ------------------------------------------------------- RAM and publish
  logic [g_MAG_WIDTH-1:0]   mem_q [0:2*g_N-1];
  logic                     display_bank_q, display_bank_d;
  logic                     write_bank_s;
  logic                     publish_s;
  logic                     frame_ready_q;
  logic [C_FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic [g_MAG_WIDTH-1:0]   rd_data_q;
  logic                     rd_valid_q;

  // The collecting side always writes the bank not on display.
  assign write_bank_s = ~display_bank_q;

  // Publish decision: the tagged last bin is being written this cycle.
  always_comb begin
    publish_s = mag_valid_s & mag_tag_s;
    if (publish_s) begin
      display_bank_d = ~display_bank_q;
      frame_count_d  = frame_count_q + C_CNT_ONE;
    end else begin
      display_bank_d = display_bank_q;
      frame_count_d  = frame_count_q;
    end
  end

  // Publish registers: bank swap, frame pulse and published-frame counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      display_bank_q <= 1'b0;
      frame_ready_q  <= 1'b0;
      frame_count_q  <= {C_FRAME_CNT_W{1'b0}};
    end else begin
      display_bank_q <= display_bank_d;
      frame_ready_q  <= publish_s;
      frame_count_q  <= frame_count_d;
    end
  end

  // Magnitude write into the collecting bank; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mag_valid_s && !i_reset) begin
      mem_q[{write_bank_s, mag_addr_s}] <= mag_s;
    end
  end

  // Display read port; bank select is sampled with the address, data holds
  // its last value between reads.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= {g_MAG_WIDTH{1'b0}};
    end else begin
      rd_valid_q <= i_rdEn;
      if (i_rdEn) begin
        rd_data_q <= mem_q[{display_bank_q, i_rdAddr}];
      end
    end
  end

  assign o_rdData     = rd_data_q;
  assign o_rdValid    = rd_valid_q;
  assign o_frameReady = frame_ready_q;
  assign o_frameCount = frame_count_q;
  assign o_seqError   = seq_error_q;

`ifdef SDFT_SPECTRUM_PEAK_EN
  // ------------------------------------------------------------------ peak
  logic [g_MAG_WIDTH-1:0] run_mag_q, run_mag_d, peak_mag_q, peak_mag_d;
  logic [C_AW-1:0]        run_addr_q, run_addr_d, peak_addr_q, peak_addr_d;

  // Running maximum over the frame being collected; bin 0 restarts it and a
  // strict compare keeps the lowest index on ties.
  always_comb begin
    run_mag_d  = run_mag_q;
    run_addr_d = run_addr_q;
    if (mag_valid_s) begin
      if ((mag_addr_s == {C_AW{1'b0}}) || (mag_s > run_mag_q)) begin
        run_mag_d  = mag_s;
        run_addr_d = mag_addr_s;
      end else begin
        run_mag_d  = run_mag_q;
        run_addr_d = run_addr_q;
      end
    end else begin
      run_mag_d  = run_mag_q;
      run_addr_d = run_addr_q;
    end
    if (publish_s) begin
      peak_mag_d  = run_mag_d;
      peak_addr_d = run_addr_d;
    end else begin
      peak_mag_d  = peak_mag_q;
      peak_addr_d = peak_addr_q;
    end
  end

  // Peak tracking and published-peak registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      run_mag_q   <= {g_MAG_WIDTH{1'b0}};
      run_addr_q  <= {C_AW{1'b0}};
      peak_mag_q  <= {g_MAG_WIDTH{1'b0}};
      peak_addr_q <= {C_AW{1'b0}};
    end else begin
      run_mag_q   <= run_mag_d;
      run_addr_q  <= run_addr_d;
      peak_mag_q  <= peak_mag_d;
      peak_addr_q <= peak_addr_d;
    end
  end

  assign o_peakAddr = peak_addr_q;
  assign o_peakMag  = peak_mag_q;
`endif

endmodule
